// File: rtl/sum_product_arbiter.sv
// Two-port round-robin front end for a shared W-cycle shift-add multiplier and adder.
// Define ARB_STATS_EN to add per-requester completed-operation counters (op_count0/op_count1).
module sum_product_arbiter #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W:0]       rsp_sum,
  output logic [2*W-1:0]   rsp_product,
`ifdef ARB_STATS_EN
  output logic [CNT_W-1:0] op_count0,
  output logic [CNT_W-1:0] op_count1,
`endif
  output logic             busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic [2*W-1:0]   a_sh_reg;
  logic [W-1:0]     b_sh_reg;
  logic [2*W-1:0]   acc_reg;
  logic [2*W-1:0]   acc_step;
  logic [CW-1:0]    cnt_reg;
  logic             rsp_id_reg;
  logic [W:0]       rsp_sum_reg;
  logic [2*W-1:0]   rsp_product_reg;
  logic             grant_any;
  logic             grant_id;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             last_step;

  // Grant falls to the port that did not win last time only when both compete.
  always_comb begin
    grant_any  = req0_valid | req1_valid;
    grant_id   = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
    sel_a      = grant_id ? req1_a : req0_a;
    sel_b      = grant_id ? req1_b : req0_b;
    acc_step   = b_sh_reg[0] ? (acc_reg + a_sh_reg) : acc_reg;
    last_step  = (cnt_reg == CW'(1));
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_next = CALC;
        end
      end
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      a_sh_reg        <= '0;
      b_sh_reg        <= '0;
      acc_reg         <= '0;
      cnt_reg         <= '0;
      rsp_id_reg      <= 1'b0;
      rsp_sum_reg     <= '0;
      rsp_product_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            a_sh_reg    <= {{W{1'b0}}, sel_a};
            b_sh_reg    <= sel_b;
            acc_reg     <= '0;
            cnt_reg     <= CW'(W);
            rsp_id_reg  <= grant_id;
            rsp_sum_reg <= {1'b0, sel_a} + {1'b0, sel_b};
          end
        end
        CALC: begin
          // Fixed W iterations regardless of operand values; no early exit.
          acc_reg  <= acc_step;
          a_sh_reg <= a_sh_reg << 1;
          b_sh_reg <= b_sh_reg >> 1;
          cnt_reg  <= cnt_reg - CW'(1);
          if (last_step) rsp_product_reg <= acc_step;
        end
        DONE: begin
          if (rsp_ready) last_grant_reg <= rsp_id_reg;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] op_count0_reg;
  logic [CNT_W-1:0] op_count1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count0_reg <= '0;
      op_count1_reg <= '0;
    end else if (state_reg == DONE && rsp_ready) begin
      if (rsp_id_reg) op_count1_reg <= op_count1_reg + CNT_W'(1);
      else            op_count0_reg <= op_count0_reg + CNT_W'(1);
    end
  end

  assign op_count0 = op_count0_reg;
  assign op_count1 = op_count1_reg;
`endif

  assign rsp_valid   = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign rsp_id      = rsp_id_reg;
  assign rsp_sum     = rsp_sum_reg;
  assign rsp_product = rsp_product_reg;

endmodule

// File: doc/sum_product_arbiter.md
Name: sum_product_arbiter

Overview:
- Shares one iterative sum/product datapath (9-bit sum, 16-bit shift-add product) between two requesters.
- Round-robin arbitration with valid/ready on each request port and on the single response port.
- Each response is tagged with the requester id.
- Sits between the operand sources and the result consumer; replaces the single-cycle multiplier with a W-cycle multiplier plus its sequencer.

Parameters:
W, 8, operand width; sum is W+1 bits, product is 2W bits
CNT_W, 16, width of optional statistics counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 holds operands valid
req0_ready  out  1  requester 0 operands accepted this cycle
req0_a  in  W  requester 0 operand a
req0_b  in  W  requester 0 operand b
req1_valid  in  1  requester 1 valid
req1_ready  out  1  requester 1 accepted
req1_a  in  W  requester 1 operand a
req1_b  in  W  requester 1 operand b
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester owning result
rsp_sum  out  W+1  a+b, zero-extended, no overflow loss
rsp_product  out  2W  a*b, unsigned
busy  out  1  high in CALC or DONE
op_count0  out  CNT_W  completed ops for requester 0 (ARB_STATS_EN only)
op_count1  out  CNT_W  completed ops for requester 1 (ARB_STATS_EN only)

Behaviour:
- Reset: state=IDLE; rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_product=0, busy=0, both ready=0, last_grant=1 (so req0 wins first), counters=0.
- Reset asserted at any time, including mid-CALC or DONE, discards the in-flight operation. No response is ever issued for it.
- IDLE:
  - Grant selection is combinational from current valids.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready=1 only for the granted requester, only in IDLE. Never both high.
  - On valid&ready edge: capture a, b and id; register sum=a+b; clear accumulator; load counter=W; go to CALC.
- CALC, exactly W cycles:
  - Each cycle: if b_sh[0], acc += a_sh (2W bits); then a_sh <<= 1, b_sh >>= 1, counter--.
  - Counter reaching 0 moves to DONE with rsp_product=acc.
  - Both readys are 0 throughout.
- DONE:
  - rsp_valid=1. rsp_id, rsp_sum and rsp_product are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: set last_grant=rsp_id, go to IDLE, and drop rsp_valid on the following edge.
- Latency: capture edge at t0 gives rsp_valid high after edge t0+W. With rsp_ready tied high, the next capture happens earliest at edge t0+W+2. Peak throughput is one op per W+2 cycles.
- Request ports follow valid/ready rules: a requester holds valid and operands stable until ready. Dropping valid before grant is legal and loses no state.
- Operands of 0 give product 0 after the full W cycles; there is no early termination.
- No starvation: under continuous requests from both ports, grants alternate 0,1,0,1...

Optional Feature:
ARB_STATS_EN
- Defined:
  - op_count0 and op_count1 are present.
  - The matching counter increments on each rsp_valid&rsp_ready handshake and wraps at 2^CNT_W-1 -> 0.
  - Counters are reset by rst_n only.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

Test Plan:
- Single request: req0 a=10 b=99, rsp_ready=1 -> req0_ready one cycle; rsp_valid after 8 cycles with id=0, sum=109, product=990. busy high 9 cycles.
- Simultaneous after reset: req0 (33,99), req1 (99,33) both held valid -> first response id=0 (sum 132, product 3267), second id=1 (same values). req1_ready never high before the first response is accepted.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, both readys 0. Accept on cycle 6 -> return to IDLE next edge.
- Boundaries: (255,255) -> sum 510, product 65025; (0,200) -> sum 200, product 0, still W cycles of latency.
- Reset mid-CALC: assert rst_n=0 at cycle 3 of CALC -> all outputs 0 asynchronously, no response afterwards. A fresh req1 (4,5) -> sum 9, product 20, id=1.
- ARB_STATS_EN: 3 completed req0 ops and 2 req1 ops -> op_count0=3, op_count1=2. A reset clears both.
